// File: rtl/player_hp_controller_if.sv
// Handshake bundle between the HP controller and the damage calculator.
// The controller owns the start pulse; the calculator returns damage, heal and completion.
interface player_hp_controller_if;
    logic       calcStart;
    logic [7:0] damage;
    logic       heal;
    logic       isComplete;

    modport master (
        output calcStart,
        input  damage,
        input  heal,
        input  isComplete
    );

    modport slave (
        input  calcStart,
        output damage,
        output heal,
        output isComplete
    );
endinterface

// File: rtl/player_hp_controller.sv
// Player hit-point controller.
// Once per video frame it kicks the damage calculator and applies the returned
// damage/heal, and it runs a frame-counted invincibility window. It parks in a
// death state until restart, and it flags a calculator that never answers.
module player_hp_controller #(
    parameter int MAX_HP        = 200,
    parameter int HEAL_AMOUNT   = 20,
    parameter int IFRAME_FRAMES = 30,
    parameter int CALC_TIMEOUT  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frameTick,
    input  logic                          restart,
    player_hp_controller_if.master        calc,
    output logic [7:0]                    hp,
    output logic                          isDead,
    output logic                          isInvincible,
    output logic                          hpChanged,
    output logic                          timeoutErr
);

    localparam logic [7:0] MAX_HP_V   = 8'(MAX_HP);
    localparam logic [7:0] HEAL_V     = 8'(HEAL_AMOUNT);
    localparam logic [7:0] IFRAME_V   = 8'(IFRAME_FRAMES);
    localparam logic [8:0] TIMEOUT_V  = 9'(CALC_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        APPLY = 2'd2,
        DEAD  = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] iframe_cnt;
    logic [7:0] timeout_cnt;
    logic [7:0] lat_damage;
    logic       lat_heal;

    logic [7:0] eff_damage;
    logic       lethal;
    logic [7:0] after_damage;
    logic [8:0] heal_sum;
    logic [7:0] healed;
    logic [7:0] applied_hp;
    logic [8:0] timeout_next;

    assign isInvincible = (iframe_cnt != 8'd0);

    // Result of one APPLY step: damage first (masked while invincible), then a clamped heal.
    always_comb begin
        eff_damage   = isInvincible ? 8'd0 : lat_damage;
        lethal       = (eff_damage >= hp);
        after_damage = hp - eff_damage;
        heal_sum     = {1'b0, after_damage} + {1'b0, HEAL_V};
        healed       = (heal_sum > {1'b0, MAX_HP_V}) ? MAX_HP_V : heal_sum[7:0];
        applied_hp   = 8'd0;
        if (!lethal) begin
            applied_hp = lat_heal ? healed : after_damage;
        end
        timeout_next = {1'b0, timeout_cnt} + 9'd1;
    end

    // Frame sequencing FSM; every output and counter is registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            hp             <= MAX_HP_V;
            calc.calcStart <= 1'b0;
            isDead         <= 1'b0;
            hpChanged      <= 1'b0;
            timeoutErr     <= 1'b0;
            iframe_cnt     <= 8'd0;
            timeout_cnt    <= 8'd0;
            lat_damage     <= 8'd0;
            lat_heal       <= 1'b0;
        end else begin
            calc.calcStart <= 1'b0;
            hpChanged      <= 1'b0;

            // A frame tick always ages the invincibility window, even if the frame is dropped.
            // Assignments further down (APPLY load, DEAD clear) take priority over this.
            if (frameTick && isInvincible && state != DEAD) begin
                iframe_cnt <= iframe_cnt - 8'd1;
            end

            case (state)
                IDLE: begin
                    if (frameTick) begin
                        calc.calcStart <= 1'b1;
                        timeout_cnt    <= 8'd0;
                        state          <= WAIT;
                    end
                end

                WAIT: begin
                    if (calc.isComplete) begin
                        lat_damage <= calc.damage;
                        lat_heal   <= calc.heal;
                        state      <= APPLY;
                    end else if (timeout_next == TIMEOUT_V) begin
                        timeoutErr <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_next[7:0];
                    end
                end

                APPLY: begin
                    hp        <= applied_hp;
                    hpChanged <= (applied_hp != hp);
                    if (lethal) begin
                        isDead     <= 1'b1;
                        iframe_cnt <= 8'd0;
                        state      <= DEAD;
                    end else begin
                        if (eff_damage != 8'd0) begin
                            iframe_cnt <= IFRAME_V;
                        end
                        state <= IDLE;
                    end
                end

                DEAD: begin
                    iframe_cnt <= 8'd0;
                    if (restart) begin
                        hp         <= MAX_HP_V;
                        hpChanged  <= (hp != MAX_HP_V);
                        isDead     <= 1'b0;
                        timeoutErr <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/player_hp_controller.md
# player_hp_controller

Owns the player's hit points and sits directly downstream of the damage calculator. Once per video frame it fires the calculator's start pulse, waits for the completion pulse, and applies the returned damage and heal. It also runs an invincibility window counted in frames and holds the death state until restart. Its outputs drive the HP bar renderer and the game-over logic.

## Interface
Parameters:
- MAX_HP, 200 — full HP and restart value; must be 1..255.
- HEAL_AMOUNT, 20 — HP added per heal event.
- IFRAME_FRAMES, 30 — invincibility length in frame ticks after a damaging hit; 1..255.
- CALC_TIMEOUT, 32 — cycles to wait for calculator completion before abandoning the frame; 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high.
- frameTick  in  1  one-cycle pulse per video frame.
- restart  in  1  level/pulse; leaves DEAD when sampled high in DEAD.
- damage  in  8  accumulated damage from the calculator, sampled on isComplete.
- heal  in  1  heal flag from the calculator, sampled on isComplete.
- isComplete  in  1  one-cycle completion pulse from the calculator.
- calcStart  out  1  registered one-cycle start pulse to the calculator.
- hp  out  8  current HP.
- isDead  out  1  high while in DEAD.
- isInvincible  out  1  high while the invincibility counter is nonzero.
- hpChanged  out  1  one-cycle pulse in the cycle after hp changes value.
- timeoutErr  out  1  sticky; set on calculator timeout, cleared only by reset or restart.

## Operation
- States: IDLE, WAIT, APPLY, DEAD. Reset enters IDLE.
- IDLE:
  - frameTick → calcStart=1 in the next cycle; state=WAIT; timeout counter=0.
- WAIT:
  - isComplete → latch damage and heal; state=APPLY.
  - Otherwise the timeout counter increments each cycle. On reaching CALC_TIMEOUT: timeoutErr=1, state=IDLE, frame discarded.
  - frameTick arriving in WAIT or APPLY does not start a new calculation (frame dropped), but it still decrements the invincibility counter.
- APPLY (exactly one cycle), in this order:
  - Effective damage d = isInvincible ? 0 : latched damage.
  - If d ≥ hp: hp=0 and next state=DEAD. Heal is ignored.
  - Else hp=hp−d. Then, if heal: hp=min(hp+HEAL_AMOUNT, MAX_HP), using a 9-bit sum before the clamp.
  - If d>0 and the player survived: invincibility counter loads IFRAME_FRAMES. The load wins over a frameTick decrement in the same cycle.
  - Next state is IDLE unless DEAD.
- Invincibility counter:
  - 8 bits; decrements by 1 on each frameTick while nonzero and not in DEAD.
  - isInvincible = (counter≠0).
- DEAD:
  - hp=0, isDead=1, counter forced to 0, calcStart never asserted.
  - restart high → hp=MAX_HP, timeoutErr=0, state=IDLE.
  - restart is ignored outside DEAD.
- A heal-only result with hp already MAX_HP leaves hp unchanged and produces no hpChanged pulse.

## Timing
- Reset values: hp=MAX_HP; calcStart, isDead, isInvincible, hpChanged, timeoutErr all 0; counters 0; state IDLE.
- Asserting reset mid-operation returns these values immediately. An in-flight calculator result is lost.
- Cycle sequence for one frame:
  - frameTick at cycle t → calcStart high at t+1.
  - isComplete at cycle c → APPLY at c+1.
  - hp and isDead update at the end of c+1, visible at c+2.
  - hpChanged high during c+2.
- Calculator completion is nominally 9 cycles after start, so one frame costs about 12 cycles, far below a frame period.
- isComplete seen outside WAIT is ignored.

## Test plan
- Hit with no invincibility: hp=200, frameTick, isComplete with damage=50, heal=0 → calcStart at t+1; hp=150 two cycles after isComplete; hpChanged pulse; isInvincible=1 for 30 frameTicks, then 0.
- Damage during invincibility: right after the previous hit, a frame returns damage=100 → hp stays 150; no hpChanged; counter continues decrementing.
- Heal clamp: hp=190, damage=0, heal=1 → hp=200. Repeat at hp=200 → hp=200 with no hpChanged.
- Lethal hit with heal: hp=50, counter 0, damage=50, heal=1 → hp=0, isDead=1, calcStart stays 0 on later frameTicks. Then restart → hp=200, isDead=0, IDLE.
- Timeout: frameTick with isComplete never asserted → timeoutErr=1 exactly 32 cycles after entering WAIT; state back to IDLE; the next frameTick issues calcStart again.
- Async reset mid-WAIT: reset asserted between calcStart and isComplete → all outputs at reset values without waiting for a clock edge; a later isComplete is ignored.
